// File: rtl/hi_put_trace_pkg.sv
// Shared major-mode encodings and load-frame timing constants for the
// HF trace put/play block.
package hi_put_trace_pkg;

  localparam logic [2:0] FPGA_MAJOR_MODE_HF_READER    = 3'd0;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_SIMULATOR = 3'd1;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_ISO14443A = 3'd2;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_SNIFF     = 3'd3;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_ISO18092  = 3'd4;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_GET_TRACE = 3'd5;
  localparam logic [2:0] FPGA_MAJOR_MODE_HF_PUT_TRACE = 3'd6;
  localparam logic [2:0] FPGA_MAJOR_MODE_OFF          = 3'd7;

  localparam int         LEN_W     = 12;
  localparam logic [6:0] CNT_WRITE = 7'd121;

  // Serial bits are sampled mid-way through each 16-cycle SSP bit period.
  function automatic logic is_sample_slot(input logic [6:0] cnt);
    return cnt[3:0] == 4'd8;
  endfunction

endpackage

// File: rtl/hi_put_trace_ram.sv
// Trace storage: DEPTH x 8 single-port RAM, falling-edge clocked, registered read.
module hi_put_trace_ram #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wd,
  output logic [7:0]               rd
);

  logic [7:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) mem[addr] <= wd;
    if (re) rd <= mem[addr];
  end

endmodule

// File: rtl/hi_put_trace.sv
// Loads a byte trace from the ARM over SSP, then replays it one sample per
// SAMPLE_DIV clocks, optionally looping.
module hi_put_trace
  import hi_put_trace_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int SAMPLE_DIV = 8
) (
  input  logic             ck_1356megb,
  input  logic             reset,
  input  logic [2:0]       major_mode,
  input  logic             play_enable,
  input  logic             loop,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic [7:0]       play_d,
  output logic             play_valid,
  output logic             play_done,
  output logic             overflow,
  output logic [LEN_W-1:0] length
);

  localparam int               AW        = $clog2(DEPTH);
  localparam int               DW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t        state;
  logic [6:0]    clock_cnt;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] div;
  logic [7:0]    shift;
  logic          done_pend;
  logic          vld_p1;
  logic          last_p1;
  logic [7:0]    rd_data_p1;

  logic          mode_put;
  logic          mode_off;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;

  assign mode_put = (major_mode == FPGA_MAJOR_MODE_HF_PUT_TRACE);
  assign mode_off = (major_mode == FPGA_MAJOR_MODE_OFF);

  // Gating on reset keeps a reset that lands on a write slot from storing a byte.
  assign ram_we   = mode_put && (state == LOAD) && (clock_cnt == CNT_WRITE) &&
                    (length != DEPTH_LEN) && !reset;
  assign ram_re   = !mode_put && !mode_off && play_enable && (state == PLAY) && (div == '0);
  assign ram_addr = (state == LOAD) ? wr_addr : rd_addr;

  hi_put_trace_ram #(.DEPTH(DEPTH)) trace_ram (
    .clk  (ck_1356megb),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wd   (shift),
    .rd   (rd_data_p1)
  );

  always_ff @(negedge ck_1356megb or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clock_cnt  <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      div        <= '0;
      shift      <= '0;
      done_pend  <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      length     <= '0;
      overflow   <= 1'b0;
      ssp_clk    <= 1'b0;
      ssp_frame  <= 1'b0;
      play_d     <= '0;
      play_valid <= 1'b0;
      play_done  <= 1'b0;
    end else begin
      ssp_clk    <= 1'b0;
      ssp_frame  <= 1'b0;
      play_valid <= 1'b0;
      play_done  <= 1'b0;
      done_pend  <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      if (mode_put) begin
        if (state != LOAD) begin
          state     <= LOAD;
          clock_cnt <= '0;
          wr_addr   <= '0;
          length    <= '0;
          overflow  <= 1'b0;
        end else begin
          clock_cnt <= clock_cnt + 7'd1;
          ssp_clk   <= ~clock_cnt[3];
          ssp_frame <= (clock_cnt[6:4] == 3'd0);
          if (is_sample_slot(clock_cnt)) shift <= {shift[6:0], ssp_dout};
          if (clock_cnt == CNT_WRITE) begin
            if (length == DEPTH_LEN) begin
              overflow <= 1'b1;
            end else begin
              wr_addr <= wr_addr + AW'(1);
              length  <= length + LEN_W'(1);
            end
          end
        end
      end else if (mode_off) begin
        state     <= IDLE;
        clock_cnt <= '0;
      end else begin
        clock_cnt <= '0;
        case (state)
          IDLE: begin
            if (play_enable) begin
              rd_addr <= '0;
              div     <= '0;
              if (length == '0) begin
                state     <= DONE;
                done_pend <= 1'b1;
              end else begin
                state <= PLAY;
              end
            end
          end
          LOAD: state <= IDLE;
          PLAY: begin
            if (!play_enable) begin
              state <= IDLE;
            end else begin
              div <= (div == DIV_LAST) ? '0 : div + DW'(1);
              // p0: read issued this edge, address advanced or wrapped
              if (div == '0) begin
                vld_p1 <= 1'b1;
                if (LEN_W'(rd_addr) + LEN_W'(1) == length) begin
                  rd_addr <= '0;
                  last_p1 <= !loop;
                end else begin
                  rd_addr <= rd_addr + AW'(1);
                end
              end
              // p1: RAM data available, present it
              if (vld_p1) begin
                play_d     <= rd_data_p1;
                play_valid <= 1'b1;
                if (last_p1) begin
                  play_done <= 1'b1;
                  state     <= DONE;
                end
              end
            end
          end
          DONE: begin
            if (done_pend) play_done <= 1'b1;
            if (!play_enable) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hi_put_trace.sv
// Directed-sequence bench with random trace bytes, checked against a queue
// model of what was loaded and when it should replay.
module tb_hi_put_trace;
  import hi_put_trace_pkg::*;

  localparam int DEPTH      = 16;
  localparam int SAMPLE_DIV = 8;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic [2:0]  major_mode  = FPGA_MAJOR_MODE_OFF;
  logic        play_enable = 1'b0;
  logic        loop        = 1'b0;
  logic        ssp_dout    = 1'b0;
  logic        ssp_clk;
  logic        ssp_frame;
  logic [7:0]  play_d;
  logic        play_valid;
  logic        play_done;
  logic        overflow;
  logic [11:0] length;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] stim  [$];
  logic [7:0] model [$];
  logic       exp_ovf;

  always #5 clk = ~clk;

  hi_put_trace #(.DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .ck_1356megb (clk),
    .reset       (reset),
    .major_mode  (major_mode),
    .play_enable (play_enable),
    .loop        (loop),
    .ssp_dout    (ssp_dout),
    .ssp_clk     (ssp_clk),
    .ssp_frame   (ssp_frame),
    .play_d      (play_d),
    .play_valid  (play_valid),
    .play_done   (play_done),
    .overflow    (overflow),
    .length      (length)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 32'({ssp_clk, ssp_frame, play_d, play_valid, play_done, overflow, length}), 32'd0);
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int k = 0; k < n; k++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  // Shift every stim byte in MSB first, one bit per 16-clock SSP period.
  task automatic load_trace(input bit chk_ssp);
    int nb;
    logic [7:0] b;
    nb = stim.size();
    model.delete();
    exp_ovf = 1'b0;
    for (int n = 0; n < nb; n++) begin
      if (n < DEPTH) model.push_back(stim[n]);
      else exp_ovf = 1'b1;
    end
    major_mode = FPGA_MAJOR_MODE_HF_PUT_TRACE;
    @(posedge clk);
    for (int i = 0; i < nb * 128; i++) begin
      if (chk_ssp && i > 0) begin
        check("ssp_clk", 32'(((i - 1) % 16) < 8), 32'(ssp_clk));
        check("ssp_frame", 32'(ssp_frame), 32'(((i - 1) % 128) < 16));
      end
      b = stim[i / 128] << ((i % 128) / 16);
      ssp_dout = b[7];
      @(posedge clk);
    end
    check("length", 32'(length), 32'(model.size()));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    major_mode = FPGA_MAJOR_MODE_HF_READER;
    ssp_dout = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("ssp_idle", 32'({ssp_clk, ssp_frame}), 32'd0);
  endtask

  task automatic play_trace(input bit lp, input int cycles);
    int idx, last, dones, n;
    n = model.size();
    idx = 0;
    last = 0;
    dones = 0;
    loop = lp;
    play_enable = 1'b1;
    for (int j = 0; j < cycles; j++) begin
      @(posedge clk);
      if (play_valid) begin
        check("play_d", 32'(play_d), 32'(model[idx % n]));
        if (idx == 0) check("first_latency", j, 32'd2);
        else check("sample_spacing", j - last, SAMPLE_DIV);
        check("done_on_last", 32'(play_done), 32'(!lp && idx == n - 1));
        last = j;
        idx++;
      end
      if (play_done) dones++;
    end
    check("valid_count", idx, lp ? (cycles - 3) / SAMPLE_DIV + 1 : n);
    check("done_count", dones, lp ? 0 : 1);
    if (!lp) check("done_hold", 32'(play_d), 32'(model[n - 1]));
    play_enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_outputs_zero("reset_held");
    reset = 1'b0;
    major_mode = FPGA_MAJOR_MODE_HF_READER;
    repeat (2) @(posedge clk);
    check_outputs_zero("after_reset");

    // Empty trace: one play_done, no samples, stays DONE while enabled.
    play_enable = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      check("zl_valid", 32'(play_valid), 32'd0);
      check("zl_done", 32'(play_done), 32'(j == 1));
    end
    play_enable = 1'b0;
    repeat (2) @(posedge clk);
    play_enable = 1'b1;
    repeat (2) @(posedge clk);
    check("zl_redone", 32'(play_done), 32'd1);
    play_enable = 1'b0;
    repeat (2) @(posedge clk);

    // Two fixed bytes with SSP timing checked, then a single pass.
    stim = {8'hA5, 8'h3C};
    load_trace(1'b1);
    play_trace(1'b0, 24);

    // Three random bytes looped for 40 cycles.
    rand_stim(3);
    load_trace(1'b0);
    play_trace(1'b1, 40);

    // Dropping play_enable with a read in flight yields no sample.
    loop = 1'b0;
    play_enable = 1'b1;
    repeat (2) @(posedge clk);
    play_enable = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      check("abort_valid", 32'(play_valid), 32'd0);
    end

    // Overfill: length saturates, overflow sticks, last slot holds byte DEPTH-1.
    rand_stim(DEPTH + 2);
    load_trace(1'b0);
    play_trace(1'b0, 8 * DEPTH + 8);

    // A new load clears overflow.
    rand_stim(1);
    load_trace(1'b0);
    play_trace(1'b0, 16);

    // Reset in the middle of playback, then a fresh load.
    rand_stim(3);
    load_trace(1'b0);
    loop = 1'b1;
    play_enable = 1'b1;
    repeat (12) @(posedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("reset_async");
    @(posedge clk);
    play_enable = 1'b0;
    loop = 1'b0;
    @(posedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    check_outputs_zero("reset_release");
    rand_stim(2);
    load_trace(1'b0);
    play_trace(1'b0, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hi_put_trace.md
HI_PUT_TRACE -- requirements
Module: hi_put_trace

Interface
REQ-001 Parameter DEPTH, 2048, trace RAM depth in bytes (power of two).
REQ-002 Parameter SAMPLE_DIV, 8, ck_1356megb cycles per played sample.
REQ-003 ck_1356megb  in  1  sole clock; all state updates on its falling edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 major_mode  in  3  FPGA major mode; `FPGA_MAJOR_MODE_HF_PUT_TRACE selects load, `FPGA_MAJOR_MODE_OFF selects idle.
REQ-006 play_enable  in  1  level; high in any other non-OFF mode requests playback.
REQ-007 loop  in  1  level; high makes playback wrap to address 0 instead of finishing.
REQ-008 ssp_dout  in  1  serial data from ARM, MSB first.
REQ-009 ssp_clk  out  1  SSP clock generated during load, ck_1356megb/16.
REQ-010 ssp_frame  out  1  SSP frame marker, one per byte.
REQ-011 play_d  out  8  current played sample.
REQ-012 play_valid  out  1  one-cycle strobe, new play_d.
REQ-013 play_done  out  1  one-cycle pulse, end of non-looped playback.
REQ-014 overflow  out  1  sticky; load attempted beyond DEPTH bytes.
REQ-015 length  out  12  bytes currently loaded (0..DEPTH).

Function
REQ-016 FSM states IDLE, LOAD, PLAY, DONE; any state -> LOAD when major_mode==PUT_TRACE; any state -> IDLE when major_mode==OFF.
REQ-017 Entry into LOAD from another state clears clock_cnt (7 bit), wr_addr, length, and overflow.
REQ-018 In LOAD, clock_cnt increments every cycle and wraps 127->0; it holds at 0 outside LOAD.
REQ-019 ssp_clk is registered ~clock_cnt[3]; ssp_frame is registered (clock_cnt[6:4]==0); both are 0 outside LOAD.
REQ-020 Bit k (k=0 MSB .. 7 LSB) of ssp_dout is sampled when clock_cnt=={k,4'd8}.
REQ-021 At clock_cnt==7'd121, the assembled byte is written to RAM[wr_addr]; then wr_addr and length increment.
REQ-022 When length==DEPTH at a write slot, the byte is discarded, length saturates, and overflow sets.
REQ-023 IDLE -> PLAY when major_mode is neither OFF nor PUT_TRACE and play_enable==1; entry clears rd_addr and the sample divider.
REQ-024 In PLAY, the divider counts 0..SAMPLE_DIV-1, and RAM[rd_addr] is read at divider==0.
REQ-025 play_d updates and play_valid pulses at divider==1 (one-cycle RAM latency), giving one sample per SAMPLE_DIV cycles.
REQ-026 After the read of rd_addr==length-1: if loop=1, rd_addr wraps to 0 seamlessly; else play_done pulses with the last play_valid and the FSM enters DONE.
REQ-027 PLAY entry with length==0 goes directly to DONE, with play_done pulsing one cycle later and no play_valid.
REQ-028 DONE holds play_d and returns to IDLE when play_enable==0.
REQ-029 play_enable falling in PLAY -> IDLE immediately; an in-flight read produces no play_valid.
REQ-030 RAM contents and length survive IDLE/PLAY/DONE, and are cleared only by LOAD entry (length) or reset.

Reset
REQ-031 Reset forces IDLE and clears clock_cnt, wr_addr, rd_addr, divider, length, and overflow.
REQ-032 All outputs are 0 during and after reset; RAM contents are undefined.
REQ-033 Reset asserted mid-load or mid-play aborts immediately, with no RAM write on the reset cycle.

Structure
REQ-034 `FPGA_MAJOR_MODE_HF_PUT_TRACE is defined alongside the existing major-mode defines in the shared FPGA define file.
REQ-035 The FSM state encodings are local constants.
REQ-036 Storage is one sub-module, trace_ram: DEPTH x 8, single port, registered read, falling-edge clocked.

Verification
REQ-037 Load 0xA5,0x3C, then play with loop=0 -> length==2; play_d 0xA5 then 0x3C, 8 cycles apart; play_done coincides with the second play_valid.
REQ-038 Load 3 bytes, then play with loop=1 for 40 cycles -> 5 play_valid pulses with sequence b0,b1,b2,b0,b1 and no play_done.
REQ-039 Load DEPTH+2 bytes -> length==DEPTH, overflow==1, and RAM[DEPTH-1] holds byte DEPTH-1.
REQ-040 Play with length==0 -> no play_valid; one play_done pulse; DONE until play_enable==0.
REQ-041 Load mode for 256 cycles -> ssp_frame high for 16 of every 128 cycles; ssp_clk period 16 cycles.
REQ-042 Reset asserted mid-play, then released -> outputs 0, FSM IDLE, and a fresh load starts at wr_addr 0.
